// File: rtl/grf_pkg.sv
// Shared sizing constants for the general register file and its write scoreboard.
package grf_pkg;
  localparam int unsigned DW       = 32;
  localparam int unsigned AW       = 5;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned ZERO_REG = 0;
  localparam int unsigned CNT_MAX  = 3;
endpackage

// File: rtl/grf_array.sv
// 2^AW x DW register storage: one synchronous write port, two asynchronous read ports.
module grf_array #(
  parameter int unsigned DW = grf_pkg::DW,
  parameter int unsigned AW = grf_pkg::AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr0,
  output logic [DW-1:0] rdata0,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1
);
  import grf_pkg::*;

  localparam int unsigned NREG = 1 << AW;
  localparam logic [AW-1:0] ZERO = AW'(ZERO_REG);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && waddr != ZERO) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata0 = (raddr0 == ZERO) ? '0 : mem[raddr0];
    rdata1 = (raddr1 == ZERO) ? '0 : mem[raddr1];
  end
endmodule

// File: rtl/grf_scoreboard.sv
// Register file with per-register in-flight write counters, writeback bypass,
// operand/issue stall generation and a sticky orphan-writeback error flag.
module grf_scoreboard #(
  parameter int unsigned DW    = grf_pkg::DW,
  parameter int unsigned AW    = grf_pkg::AW,
  parameter int unsigned CNT_W = grf_pkg::CNT_W
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic          rs_use,
  input  logic          rt_use,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic          rs_busy,
  output logic          rt_busy,
  output logic          stall,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_addr,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          flush,
  output logic          sb_err
);
  import grf_pkg::*;

  localparam int unsigned    NREG = 1 << AW;
  localparam logic [AW-1:0]  ZERO = AW'(ZERO_REG);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CNT_MAX);

  logic [CNT_W-1:0] cnt [NREG];
  logic [DW-1:0]    arr_rs, arr_rt;
  logic             wb_live, rs_hit, rt_hit, full, accept;

  grf_array #(.DW(DW), .AW(AW)) u_array (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (wb_valid),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr0 (rs_addr),
    .rdata0 (arr_rs),
    .raddr1 (rt_addr),
    .rdata1 (arr_rt)
  );

  // A retiring write hides its own pending count; a writeback with nothing
  // pending never makes an operand look busy.
  always_comb begin
    wb_live = wb_valid && wb_addr != ZERO;
    rs_hit  = wb_live && wb_addr == rs_addr;
    rt_hit  = wb_live && wb_addr == rt_addr;
    rs_data = rs_hit ? wb_data : arr_rs;
    rt_data = rt_hit ? wb_data : arr_rt;
    rs_busy = (cnt[rs_addr] > CNT_W'(1)) || (cnt[rs_addr] == CNT_W'(1) && !rs_hit);
    rt_busy = (cnt[rt_addr] > CNT_W'(1)) || (cnt[rt_addr] == CNT_W'(1) && !rt_hit);
    full    = issue_valid && issue_addr != ZERO && cnt[issue_addr] == CNT_FULL &&
              !(wb_live && wb_addr == issue_addr);
    stall   = (rs_use && rs_busy) || (rt_use && rt_busy) || full;
    accept  = issue_valid && !stall && !flush && issue_addr != ZERO;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (flush) begin
      for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (accept && issue_addr == AW'(r) && !(wb_live && wb_addr == AW'(r)))
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (wb_live && wb_addr == AW'(r) && !(accept && issue_addr == AW'(r)) &&
                 cnt[r] != '0)
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      sb_err <= 1'b0;
    else if (wb_live && !flush && cnt[wb_addr] == '0 && !(accept && issue_addr == wb_addr))
      sb_err <= 1'b1;
  end
endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed-vector bench: the driver queues expected outputs, a negedge monitor compares them.
module tb_grf_scoreboard;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  rs_addr = '0, rt_addr = '0, issue_addr = '0, wb_addr = '0;
  logic        rs_use = 1'b0, rt_use = 1'b0, issue_valid = 1'b0, wb_valid = 1'b0, flush = 1'b0;
  logic [31:0] wb_data = '0;
  logic [31:0] rs_data, rt_data;
  logic        rs_busy, rt_busy, stall, sb_err;

  typedef struct {
    string       name;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic        rsb;
    logic        rtb;
    logic        st;
    logic        er;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic probe = 1'b0;
  int   tests = 0;
  int   fails = 0;

  grf_scoreboard #(.DW(32), .AW(5), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_use(rs_use), .rt_use(rt_use),
    .rs_data(rs_data), .rt_data(rt_data), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .stall(stall), .issue_valid(issue_valid), .issue_addr(issue_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (probe) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL monitor: output sampled with no expectation queued");
      end else begin
        e = q.pop_front();
        chk({e.name, ".rs_data"}, rs_data, e.rsd);
        chk({e.name, ".rt_data"}, rt_data, e.rtd);
        chk({e.name, ".rs_busy"}, {31'b0, rs_busy}, {31'b0, e.rsb});
        chk({e.name, ".rt_busy"}, {31'b0, rt_busy}, {31'b0, e.rtb});
        chk({e.name, ".stall"},   {31'b0, stall},   {31'b0, e.st});
        chk({e.name, ".sb_err"},  {31'b0, sb_err},  {31'b0, e.er});
      end
    end
  end

  task automatic drive(input logic iv, input logic [4:0] ia,
                       input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic fl,
                       input logic [4:0] rsa, input logic rsu,
                       input logic [4:0] rta, input logic rtu);
    issue_valid = iv; issue_addr = ia;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    flush = fl;
    rs_addr = rsa; rs_use = rsu; rt_addr = rta; rt_use = rtu;
  endtask

  task automatic exp_push(input string n, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic rsb, input logic rtb, input logic st, input logic er);
    exp_t x;
    x.name = n; x.rsd = rsd; x.rtd = rtd; x.rsb = rsb; x.rtb = rtb; x.st = st; x.er = er;
    q.push_back(x);
    probe = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    //     iv ia  wv wa  wd            fl rs  ru rt  tu
    drive(0, 0,  0, 0,  32'h0,        0, 5,  1, 0,  1); exp_push("reset",   0, 0, 0, 0, 0, 0); step();
    drive(1, 8,  0, 0,  32'h0,        0, 0,  0, 0,  0); exp_push("iss8",    0, 0, 0, 0, 0, 0); step();
    drive(0, 0,  0, 0,  32'h0,        0, 8,  1, 0,  0); exp_push("pend8",   0, 0, 1, 0, 1, 0); step();
    drive(0, 0,  1, 8,  32'hDEADBEEF, 0, 8,  1, 8,  1); exp_push("byp8", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0); step();
    drive(0, 0,  0, 0,  32'h0,        0, 8,  1, 8,  1); exp_push("rd8",  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0); step();

    drive(1, 3,  0, 0,  32'h0,        0, 0,  0, 0,  0); step();
    drive(1, 3,  0, 0,  32'h0,        0, 0,  0, 0,  0); step();
    drive(1, 3,  0, 0,  32'h0,        0, 3,  0, 0,  0); exp_push("iss3c",   0, 0, 1, 0, 0, 0); step();
    drive(1, 3,  0, 0,  32'h0,        0, 3,  0, 0,  0); exp_push("full3",   0, 0, 1, 0, 1, 0); step();
    drive(1, 3,  1, 3,  32'h33,       0, 3,  0, 0,  0); exp_push("wbiss3",  32'h33, 0, 1, 0, 0, 0); step();
    drive(0, 0,  1, 3,  32'h44,       0, 3,  0, 0,  0); exp_push("wb3a",    32'h44, 0, 1, 0, 0, 0); step();
    drive(0, 0,  1, 3,  32'h45,       0, 3,  0, 0,  0); exp_push("wb3b",    32'h45, 0, 1, 0, 0, 0); step();
    drive(0, 0,  0, 0,  32'h0,        0, 3,  1, 0,  0); exp_push("cnt1",    32'h45, 0, 1, 0, 1, 0); step();
    drive(0, 0,  1, 3,  32'h46,       0, 3,  1, 0,  0); exp_push("wb3c",    32'h46, 0, 0, 0, 0, 0); step();

    drive(1, 0,  0, 0,  32'h0,        0, 0,  1, 3,  1); exp_push("iss0",    0, 32'h46, 0, 0, 0, 0); step();
    drive(0, 0,  1, 0,  32'h1234,     0, 0,  1, 0,  1); exp_push("wb0",     0, 0, 0, 0, 0, 0); step();
    drive(0, 0,  0, 0,  32'h0,        0, 0,  1, 3,  1); exp_push("zero",    0, 32'h46, 0, 0, 0, 0); step();

    drive(1, 9,  0, 0,  32'h0,        0, 0,  0, 0,  0); step();
    drive(1, 10, 1, 12, 32'h77,       1, 9,  0, 12, 0); exp_push("flush",   0, 32'h77, 1, 0, 0, 0); step();
    drive(0, 0,  0, 0,  32'h0,        0, 9,  1, 10, 1); exp_push("flushed", 0, 0, 0, 0, 0, 0); step();
    drive(0, 0,  1, 9,  32'h55,       0, 5,  1, 12, 1); exp_push("wb9",     0, 32'h77, 0, 0, 0, 0); step();
    drive(0, 0,  0, 0,  32'h0,        0, 9,  1, 0,  0); exp_push("sberr",   32'h55, 0, 0, 0, 0, 1); step();
    drive(0, 0,  0, 0,  32'h0,        0, 9,  1, 0,  0); exp_push("sticky",  32'h55, 0, 0, 0, 0, 1); step();

    drive(1, 4,  0, 0,  32'h0,        0, 0,  0, 0,  0); step();
    drive(0, 0,  0, 0,  32'h0,        0, 4,  1, 9,  1); exp_push("rstmid",  0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    drive(0, 0,  1, 4,  32'h99,       0, 4,  1, 0,  0); exp_push("postrst", 32'h99, 0, 0, 0, 0, 0); step();
    drive(0, 0,  0, 0,  32'h0,        0, 4,  1, 9,  1); exp_push("errpost", 32'h99, 0, 0, 0, 0, 1); step();

    drive(0, 0,  0, 0,  32'h0,        0, 0,  0, 0,  0);
    repeat (2) step();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
